// File: rtl/types_pkg.sv
// Shared pipeline types for rename and the branch FU, plus the checkpoint slot count.
package types_pkg;

  localparam int CKPT_DEPTH = 4;
  localparam int ROB_TAG_W  = 6;
  localparam int FL_PTR_W   = 6;
  localparam int GHIST_W    = 8;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [FL_PTR_W-1:0]  fl_head;
    logic [GHIST_W-1:0]   ghist;
  } rename_checkpoint;

  typedef struct packed {
    logic                 fu_b_done;
    logic                 mispredict;
    logic [ROB_TAG_W-1:0] mispredict_tag;
    logic [31:0]          target_pc;
  } b_data;

endpackage

// File: rtl/ckpt_match.sv
// Oldest-first tag search over live checkpoint slots, rotated so that head is the oldest.
module ckpt_match #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int TAG_W = 6
) (
  input  logic [DEPTH-1:0]            live,
  input  logic [DEPTH-1:0][TAG_W-1:0] tags,
  input  logic [PTR_W-1:0]            head,
  input  logic [TAG_W-1:0]            key,
  output logic                        hit,
  output logic [PTR_W-1:0]            idx
);

  logic [DEPTH-1:0] eq;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign eq[i] = live[i] && (tags[i] == key);
  end

  // Walk youngest-to-oldest so the last assignment is the oldest match.
  always_comb begin
    hit = 1'b0;
    idx = head;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (eq[head + PTR_W'(k)]) begin
        hit = 1'b1;
        idx = head + PTR_W'(k);
      end
    end
  end

endmodule

// File: rtl/ckpt_recovery_buf.sv
// Branch checkpoint buffer: rename saves, branch FU frees or restores (with younger flush).
// `CKPT_RESTORE_BYPASS_EN makes restore combinational (0-cycle) instead of registered.
module ckpt_recovery_buf
  import types_pkg::*;
#(
  parameter int DEPTH = CKPT_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             save_valid,
  input  rename_checkpoint save_data,
  output logic             save_ready,
  input  b_data            br_in,
  output logic             restore_valid,
  output rename_checkpoint restore_data,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

`ifdef CKPT_RESTORE_BYPASS_EN
  localparam int STAGES = 0;
`else
  localparam int STAGES = 1;
`endif

  rename_checkpoint                     slots [DEPTH];
  logic [DEPTH-1:0][ROB_TAG_W-1:0]      slot_tags;
  logic [DEPTH-1:0]                     live, live_nxt;
  logic [PTR_W-1:0]                     head, tail, head_nxt, rel_m, rel_i;
  logic                                 mp_ev, rh_ev, m_hit, mp_hit, reclaim, save_fire;
  logic [PTR_W-1:0]                     m_idx;
  logic [STAGES:0]                      vld_pipe;
  rename_checkpoint                     restore_q;
  logic                                 br_unused;

  assign br_unused = ^br_in.target_pc;

  for (genvar i = 0; i < DEPTH; i++) begin : g_tag
    assign slot_tags[i] = slots[i].rob_tag;
  end

  ckpt_match #(.DEPTH(DEPTH), .PTR_W(PTR_W), .TAG_W(ROB_TAG_W)) u_match (
    .live (live),
    .tags (slot_tags),
    .head (head),
    .key  (br_in.mispredict_tag),
    .hit  (m_hit),
    .idx  (m_idx)
  );

  assign mp_ev      = br_in.fu_b_done && br_in.mispredict;
  assign rh_ev      = br_in.fu_b_done && !br_in.mispredict;
  assign mp_hit     = mp_ev && m_hit;
  assign full       = (count == (PTR_W+1)'(DEPTH));
  assign empty      = (count == '0);
  assign save_ready = !full && !mp_ev;
  assign save_fire  = save_valid && save_ready;
  // An unmatched mispredict freezes all state, reclaim included.
  assign reclaim    = (count != '0) && !live[head] && !(mp_ev && !m_hit);
  assign head_nxt   = reclaim ? head + PTR_W'(1) : head;
  assign rel_m      = m_idx - head;

  always_comb begin
    live_nxt = live;
    rel_i    = '0;
    if (save_fire)
      live_nxt[tail] = 1'b1;
    if (rh_ev && m_hit)
      live_nxt[m_idx] = 1'b0;
    if (mp_hit) begin
      for (int i = 0; i < DEPTH; i++) begin
        rel_i = PTR_W'(i) - head;
        if (rel_i >= rel_m)
          live_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      live      <= '0;
      restore_q <= '0;
    end else begin
      head <= head_nxt;
      live <= live_nxt;
      if (mp_hit) begin
        tail      <= m_idx;
        count     <= {1'b0, m_idx - head_nxt};
        restore_q <= slots[m_idx];
      end else begin
        if (save_fire)
          tail <= tail + PTR_W'(1);
        case ({save_fire, reclaim})
          2'b10:   count <= count + (PTR_W+1)'(1);
          2'b01:   count <= count - (PTR_W+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (save_fire)
      slots[tail] <= save_data;
  end

  assign vld_pipe[0] = mp_hit;

  for (genvar s = 1; s <= STAGES; s++) begin : g_vld
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_pipe[s] <= 1'b0;
      else        vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  assign restore_valid = vld_pipe[STAGES];

`ifdef CKPT_RESTORE_BYPASS_EN
  assign restore_data = mp_hit ? slots[m_idx] : restore_q;
`else
  assign restore_data = restore_q;
`endif

endmodule

// File: tb/tb_ckpt_recovery_buf.sv
// Directed table-driven bench for ckpt_recovery_buf (registered restore build).
module tb_ckpt_recovery_buf;
  import types_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             save_valid;
  rename_checkpoint save_data;
  logic             save_ready;
  b_data            br_in;
  logic             restore_valid;
  rename_checkpoint restore_data;
  logic [2:0]       count;
  logic             full, empty;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic       sv;
    logic [5:0] stag;
    logic       done;
    logic       mp;
    logic [5:0] mtag;
    int         cnt;
    logic       full;
    logic       rv;
    logic [5:0] rtag;
  } vec_t;

  vec_t tbl[$];

  ckpt_recovery_buf dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .save_valid    (save_valid),
    .save_data     (save_data),
    .save_ready    (save_ready),
    .br_in         (br_in),
    .restore_valid (restore_valid),
    .restore_data  (restore_data),
    .count         (count),
    .full          (full),
    .empty         (empty)
  );

  always #5 clk = ~clk;

  function automatic rename_checkpoint mk(input logic [5:0] t);
    rename_checkpoint c;
    c.rob_tag = t;
    c.fl_head = t + 6'd1;
    c.ghist   = {2'b10, t};
    return c;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic sv, input logic [5:0] stag, input logic done, input logic mp,
                     input logic [5:0] mtag, input int cnt, input logic f, input logic rv,
                     input logic [5:0] rtag);
    vec_t v;
    v.sv = sv; v.stag = stag; v.done = done; v.mp = mp; v.mtag = mtag;
    v.cnt = cnt; v.full = f; v.rv = rv; v.rtag = rtag;
    tbl.push_back(v);
  endtask

  task automatic idle();
    save_valid = 1'b0;
    save_data  = '0;
    br_in      = '0;
  endtask

  task automatic drive(input logic sv, input logic [5:0] stag, input logic done, input logic mp,
                       input logic [5:0] mtag);
    save_valid           = sv;
    save_data            = mk(stag);
    br_in                = '0;
    br_in.fu_b_done      = done;
    br_in.mispredict     = mp;
    br_in.mispredict_tag = mtag;
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v.sv, v.stag, v.done, v.mp, v.mtag);
    @(posedge clk); #1;
    idle(); #1;
    chk("count", idx, int'(count), v.cnt);
    chk("full", idx, int'(full), int'(v.full));
    chk("empty", idx, int'(empty), int'(v.cnt == 0));
    chk("save_ready", idx, int'(save_ready), int'(!v.full));
    chk("restore_valid", idx, int'(restore_valid), int'(v.rv));
    chk("restore_tag", idx, int'(restore_data.rob_tag), int'(v.rtag));
  endtask

  initial begin
    //   sv stag dn mp mtag cnt full rv rtag
    add(1, 3,  0, 0, 0,  1, 0, 0, 0);   // fill 3,7,9,12
    add(1, 7,  0, 0, 0,  2, 0, 0, 0);
    add(1, 9,  0, 0, 0,  3, 0, 0, 0);
    add(1, 12, 0, 0, 0,  4, 1, 0, 0);
    add(1, 15, 0, 0, 0,  4, 1, 0, 0);   // fifth save refused
    add(0, 0,  1, 1, 7,  1, 0, 1, 7);   // mispredict 7 flushes 7,9,12
    add(0, 0,  0, 0, 0,  1, 0, 0, 7);   // restore_data holds
    add(1, 21, 0, 0, 0,  2, 0, 0, 7);   // lands in old slot of 7
    add(0, 0,  1, 1, 20, 2, 0, 0, 7);   // unmatched mispredict
    add(0, 0,  1, 1, 21, 1, 0, 1, 21);  // count=1 proves slot 1
    add(1, 7,  0, 0, 0,  2, 0, 0, 21);
    add(1, 9,  0, 0, 0,  3, 0, 0, 21);
    add(0, 0,  1, 0, 7,  3, 0, 0, 21);  // hit behind head
    add(0, 0,  1, 0, 3,  3, 0, 0, 21);  // hit head
    add(0, 0,  0, 0, 0,  2, 0, 0, 21);
    add(0, 0,  0, 0, 0,  1, 0, 0, 21);
    add(0, 0,  0, 0, 0,  1, 0, 0, 21);
    add(0, 0,  1, 1, 9,  0, 0, 1, 9);   // head is tag 9
    add(1, 1,  0, 0, 0,  1, 0, 0, 9);   // wrap fill
    add(1, 2,  0, 0, 0,  2, 0, 0, 9);
    add(1, 3,  0, 0, 0,  3, 0, 0, 9);
    add(1, 4,  0, 0, 0,  4, 1, 0, 9);
    add(0, 0,  1, 0, 1,  4, 1, 0, 9);
    add(0, 0,  1, 1, 3,  1, 0, 1, 3);   // mispredict + reclaim
    add(0, 0,  0, 0, 0,  1, 0, 0, 3);
    add(1, 2,  0, 0, 0,  2, 0, 0, 3);   // duplicate tag 2
    add(0, 0,  1, 1, 2,  0, 0, 1, 2);   // oldest duplicate wins
    add(1, 5,  0, 0, 0,  1, 0, 0, 2);
    add(1, 6,  0, 0, 0,  2, 0, 0, 2);
    add(1, 7,  0, 0, 0,  3, 0, 0, 2);
    add(0, 0,  1, 1, 7,  2, 0, 1, 7);   // back-to-back mispredicts
    add(0, 0,  1, 1, 5,  0, 0, 1, 5);
    add(0, 0,  0, 0, 0,  0, 0, 0, 5);
    add(1, 8,  0, 0, 0,  1, 0, 0, 5);

    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_count", 0, int'(count), 0);
    chk("rst_empty", 0, int'(empty), 1);
    chk("rst_full", 0, int'(full), 0);
    chk("rst_save_ready", 0, int'(save_ready), 1);
    chk("rst_restore_valid", 0, int'(restore_valid), 0);

    foreach (tbl[i]) apply(tbl[i], i + 1);

    // save and mispredict together: save is dropped
    drive(1'b1, 6'd9, 1'b1, 1'b1, 6'd8);
    #1 chk("coll_save_ready", 100, int'(save_ready), 0);
    @(posedge clk); #1;
    idle(); #1;
    chk("coll_count", 101, int'(count), 0);
    chk("coll_restore_valid", 101, int'(restore_valid), 1);
    chk("coll_restore_tag", 101, int'(restore_data.rob_tag), 8);
    chk("coll_restore_fl", 101, int'(restore_data.fl_head), 9);
    @(posedge clk); #1;
    chk("coll_count_after", 102, int'(count), 0);
    chk("coll_rv_after", 102, int'(restore_valid), 0);

    // reset asserted in the restore cycle
    drive(1'b1, 6'd4, 1'b0, 1'b0, 6'd0);
    @(posedge clk); #1;
    drive(1'b0, 6'd0, 1'b1, 1'b1, 6'd4);
    @(posedge clk); #1;
    idle(); #1;
    chk("mid_rv_before", 103, int'(restore_valid), 1);
    chk("mid_count_before", 103, int'(count), 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rv", 104, int'(restore_valid), 0);
    chk("mid_data", 104, int'(restore_data), 0);
    chk("mid_count", 104, int'(count), 0);
    chk("mid_empty", 104, int'(empty), 1);
    @(posedge clk); #1 rst_n = 1'b1;
    drive(1'b1, 6'd11, 1'b0, 1'b0, 6'd0);
    @(posedge clk); #1;
    idle(); #1;
    chk("post_rst_count", 105, int'(count), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ckpt_recovery_buf.md
# ckpt_recovery_buf

Branch checkpoint buffer between rename and the branch FU. Rename pushes one `rename_checkpoint` per in-flight branch. The buffer consumes branch resolutions from the branch FU's `b_data`:

- **Correct resolution:** frees that branch's checkpoint.
- **Mispredict:** returns the matching checkpoint to rename for map/free-list restore, and discards it together with every younger checkpoint.

## Interface
Parameters:
- `DEPTH`, 4: checkpoint slots, a power of two, ≥ 2.
- `PTR_W`, `$clog2(DEPTH)`: slot pointer width.

Ports:
- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: asynchronous, active-low reset. This is the only reset.
- `save_valid`, in, 1: rename presents a checkpoint this cycle.
- `save_data`, in, `rename_checkpoint`: checkpoint payload. `rob_tag` identifies the branch.
- `save_ready`, out, 1: buffer accepts `save_data` this cycle.
- `br_in`, in, `b_data`: branch FU result. Only `fu_b_done`, `mispredict` and `mispredict_tag` are used.
- `restore_valid`, out, 1: single-cycle pulse; `restore_data` is valid.
- `restore_data`, out, `rename_checkpoint`: checkpoint to restore.
- `count`, out, `PTR_W+1`: occupied slots.
- `full`, out, 1: `count == DEPTH`.
- `empty`, out, 1: `count == 0`.

## Operation
- **Storage.** Circular buffer with `head` (oldest slot), `tail` (next allocation), a per-slot `live` bit and an occupancy counter.
  - Age order is buffer position from `head`, never the numeric `rob_tag`, because tags wrap.
- **Save.**
  - `save_ready = !full && !(br_in.fu_b_done && br_in.mispredict)`.
  - When `save_valid && save_ready`: write the slot at `tail`, set its `live` bit, advance `tail` (wraps at `DEPTH`), increment `count`.
- **Resolve-hit** (`fu_b_done && !mispredict`):
  - Clear `live` on the oldest live slot whose `rob_tag` equals `mispredict_tag`.
  - The slot is not reclaimed immediately.
- **Head reclaim.** Each cycle, if `count != 0` and the slot at `head` is not live, advance `head` by one and decrement `count`. Reclaim is limited to one slot per cycle.
- **Mispredict** (`fu_b_done && mispredict`):
  - Locate the oldest live slot `m` with a matching tag.
  - Output that slot's payload as `restore_data` with `restore_valid` = 1.
  - Clear `live` for `m` and every slot from `m` up to `tail`.
  - Set `tail = m` and `count = m - head`, computed modulo `DEPTH`.
- **Mispredict with no match:** no restore and no state change. This case is a software error.
- **Simultaneous events:**
  - Mispredict blocks save in the same cycle; the save is not written.
  - Resolve-hit, save and head reclaim may all occur in the same cycle. `count` nets +1/−1 accordingly.
  - A mispredict combined with a reclaim uses the pre-reclaim `head`; after the update, `count` equals the distance from the new `head` to the new `tail`.
- **Reset** (asserted at any time, including mid-restore): `head = tail = count = 0`, all `live` = 0, `restore_valid` = 0, `restore_data` = 0. Reset values of the remaining outputs: `save_ready` = 1, `full` = 0, `empty` = 1.

## Timing
- **Save:** accepted at the clock edge. Visible in `count` one cycle later.
- **Resolve-hit:** the freed slot leaves `count` at the earliest one cycle later, and only once it reaches `head`.
- **Restore:** registered by default.
  - `restore_valid` pulses exactly one cycle, in the cycle after `br_in` shows the mispredict.
  - `restore_data` holds its last value when `restore_valid` = 0.
- **Save back-pressure:** a save that completes the buffer makes `full` = 1 (and therefore `save_ready` = 0) starting the next cycle.
- **Back-to-back mispredicts** on consecutive cycles are legal. Each mispredict searches the state left by the previous one.

## Configuration
`CKPT_RESTORE_BYPASS_EN`:
- **Defined:** `restore_valid` and `restore_data` are combinational from `br_in` and the buffer. Restore latency is 0, in the same cycle as the mispredict. State updates still occur at the edge.
- **Undefined:** registered restore with 1-cycle latency, as described under Timing.

## Structure
- `rename_checkpoint` and `b_data` come from `types_pkg`.
- Add `CKPT_DEPTH` (default 4) to `types_pkg` as a localparam so that rename and this block agree on the slot count.
- One sub-module, `ckpt_match`: a combinational oldest-first priority search, rotated by `head`. It returns the hit flag and the slot index for a tag compare against the live slots. It serves both resolve-hit and mispredict.

## Test plan
- **Reset:** reset -> `empty` = 1, `count` = 0, `save_ready` = 1, `restore_valid` = 0.
- **Fill:** save tags 3, 7, 9, 12 -> `full` = 1 and `save_ready` = 0; a fifth save is not stored and `count` stays 4.
- **Out-of-order hits:** with tags 3, 7, 9 stored, hit on 7 -> `count` stays 3. Then hit on 3 -> `count` falls 3→2→1 over two cycles, and `head` points at tag 9.
- **Mispredict:** with tags 3, 7, 9, 12 stored, mispredict tag 7 -> the next cycle shows `restore_valid` = 1 with `restore_data.rob_tag` = 7 and `count` = 1. A subsequent save lands in the slot that held 7.
- **Unmatched mispredict:** mispredict tag 20 -> no `restore_valid`, `count` unchanged.
- **Collision and mid-op reset:** mispredict and `save_valid` in the same cycle -> the save is dropped. Reset asserted in the restore cycle -> `restore_valid` = 0 immediately.
